// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble gating.
// Optional stall/bubble performance counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_skid_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter bit          ZERO_REG_GUARD = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [DATA_W-1:0]     in_alu_out,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic [DATA_W-1:0]     in_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic [DATA_W-1:0]     out_alu_out,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic [DATA_W-1:0]     out_read_data
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [DATA_W-1:0]     alu_out;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     read_data;
  } entry_t;

  // StSkid always implies the main register is also valid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be nonzero");
  end

  state_e state_q, state_d;
  entry_t main_q, skid_q;
  entry_t in_entry;

  logic accept;
  logic take;
  logic main_load;
  logic main_from_skid;
  logic skid_load;

  always_comb begin
    in_entry            = '0;
    in_entry.reg_write  = in_reg_write & ~(ZERO_REG_GUARD & (in_write_reg == '0));
    in_entry.mem_to_reg = in_mem_to_reg;
    in_entry.alu_out    = in_alu_out;
    in_entry.write_reg  = in_write_reg;
    in_entry.read_data  = in_read_data;
  end

  // in_ready depends only on stored state, so there is no ready path through the stage.
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StFull;
            main_load = 1'b1;
          end
        end
        StFull: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = StSkid;
            skid_load = 1'b1;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (take) begin
            state_d        = StFull;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_entry;
      end
    end
  end

  // Stale data may sit in main_q after a flush; the valid gate keeps it from writing.
  assign out_reg_write  = out_valid & main_q.reg_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_alu_out    = main_q.alu_out;
  assign out_write_reg  = main_q.write_reg;
  assign out_read_data  = main_q.read_data;

`ifdef MEM_WB_PERF_CNT_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = out_valid & ~out_ready & ~(&stall_cnt);
  assign bubble_inc = ~out_valid & ~(&bubble_cnt);

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_inc) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble_inc) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register. Carries memory-stage results (control + ALU result + load data + destination register) into write-back.
- Adds a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, synchronous flush, and bubble gating.
- Sits between the memory stage and the register-file write port of the pipelined MIPS core.

Parameters:
- DATA_W, 32, width of ALU result and load data.
- REG_ADDR_W, 5, width of destination register index.
- ZERO_REG_GUARD, 1, when 1 a write to register index 0 is squashed at capture.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; drops all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals NOT skid_valid
- in_reg_write  in  1  RegWrite from MEM
- in_mem_to_reg  in  1  MemtoReg from MEM
- in_alu_out  in  DATA_W  ALU result from MEM
- in_write_reg  in  REG_ADDR_W  destination register
- in_read_data  in  DATA_W  data-memory read data
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumer accepts
- out_reg_write  out  1  gated RegWrite: main_valid AND main.reg_write
- out_mem_to_reg  out  1  MemtoReg to WB
- out_alu_out  out  DATA_W  ALU result to WB
- out_write_reg  out  REG_ADDR_W  destination to WB
- out_read_data  out  DATA_W  load data to WB

Behaviour:
- Storage: main register (drives outputs) plus skid register; each has a valid bit. State encoding: EMPTY (none valid), FULL (main only), SKID (main + skid). SKID with main invalid is illegal.
- Reset (reset=0, asynchronous): both valid bits 0, all stored fields 0. Outputs: out_valid=0, out_reg_write=0, other outputs 0, in_ready=1.
- Input accept: accept = in_valid AND in_ready. Output take: take = out_valid AND out_ready.
- Transitions (no flush):
  - EMPTY + accept -> FULL; input captured into main.
  - FULL + accept + take -> FULL; main replaced by input.
  - FULL + accept + no take -> SKID; input captured into skid.
  - FULL + take + no accept -> EMPTY.
  - SKID + take -> FULL; skid moves to main. accept is impossible because in_ready=0.
  - Otherwise hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 entry/cycle while out_ready=1.
- in_ready is combinational from the skid valid bit only; it does not depend on out_ready in the same cycle, so there is no combinational ready path.
- flush=1 at an edge: both valids cleared, state -> EMPTY. An accept in that cycle is dropped (flush wins). Data fields may retain their values; out_reg_write is forced 0 regardless.
- Zero-register guard (ZERO_REG_GUARD=1): if in_write_reg==0 at capture, the stored reg_write is 0.
- Outputs are stable while out_valid=1 and out_ready=0.
- Data fields pass unmodified; no width conversion.

Optional Feature:
- Macro: MEM_WB_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W], both reset to 0.
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at all-ones and are cleared by reset only, not by flush.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, out_reg_write=0, in_ready=1, all outputs 0; after release the first accept appears 1 cycle later.
- Streaming: out_ready=1, 4 back-to-back entries with alu_out 0x10..0x13 -> outputs 0x10..0x13 on consecutive cycles, in_ready constantly 1.
- Backpressure: entries A=0xAAAA0001, B=0xBBBB0002 accepted, out_ready=0 from the cycle A is shown -> state SKID, in_ready=0, A held. Raise out_ready -> A then B delivered, nothing lost or duplicated.
- Flush: in SKID state assert flush with in_valid=1 -> next cycle out_valid=0, out_reg_write=0, in_ready=1; the flushed-cycle input is never output.
- Zero guard: in_reg_write=1, in_write_reg=0 -> out_valid=1, out_reg_write=0. The same entry with write_reg=5 -> out_reg_write=1.
- Perf (MEM_WB_PERF_CNT_EN, CNT_W=4): hold out_ready=0 with a valid entry for 20 cycles -> stall_cnt saturates at 15.
